name_issue_unit: RTL and testbench

Per-channel name serializer in front of the FIB lookup pipeline. It accepts whole names, up to `MAX_NAME_LENGTH` words each, on `NUM_CHANNELS` independent issue lanes. It replays each name one word per cycle, tagged with its word index and first/last flags, under valid/ready backpressure. It generalises the fixed dual-issue, fixed-length word feed to N lanes, variable name length and stall support.

---
 rtl/name_issue_unit.sv | 150 +++++++++++++++
 tb/tb_name_issue_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/name_issue_unit.sv
// rtl/name_issue_unit.sv - per-lane name serializer feeding the FIB lookup pipeline
// Optional statistics counters: NAME_ISSUE_STATS_EN
module name_issue_unit #(
  parameter int NUM_CHANNELS      = 2,
  parameter int WORD_SIZE         = 32,
  parameter int MAX_NAME_LENGTH   = 8,
  parameter int STRIDE_INDEX_SIZE = 3,
  parameter int LEN_SIZE          = 4,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                                            clk_in,
  input  logic                                            rst_n_in,
  input  logic [NUM_CHANNELS*WORD_SIZE*MAX_NAME_LENGTH-1:0] name_in,
  input  logic [NUM_CHANNELS*LEN_SIZE-1:0]                name_len_in,
  input  logic [NUM_CHANNELS-1:0]                         name_valid_in,
  output logic [NUM_CHANNELS-1:0]                         name_ready_out,
  output logic [NUM_CHANNELS*WORD_SIZE-1:0]               word_out,
  output logic [NUM_CHANNELS*STRIDE_INDEX_SIZE-1:0]       word_idx_out,
  output logic [NUM_CHANNELS-1:0]                         word_first_out,
  output logic [NUM_CHANNELS-1:0]                         word_last_out,
  output logic [NUM_CHANNELS-1:0]                         word_valid_out,
  input  logic [NUM_CHANNELS-1:0]                         word_ready_in,
  output logic                                            busy_out
`ifdef NAME_ISSUE_STATS_EN
  ,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0]             names_issued_out
`endif
);

  localparam int NAME_W = WORD_SIZE * MAX_NAME_LENGTH;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  if ((2 ** STRIDE_INDEX_SIZE) < MAX_NAME_LENGTH || (2 ** LEN_SIZE) <= MAX_NAME_LENGTH ||
      COUNT_WIDTH < 1) begin : g_param_check
    $error("name_issue_unit: index/length/count widths too small for MAX_NAME_LENGTH");
  end

  logic [NUM_CHANNELS-1:0] issuing;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_lane
    state_t                       state_q, state_d;
    logic [NAME_W-1:0]            name_q;
    logic [LEN_SIZE-1:0]          len_q;
    logic [STRIDE_INDEX_SIZE-1:0] idx_q;
    logic [STRIDE_INDEX_SIZE-1:0] idx_nxt;
    logic [WORD_SIZE-1:0]         word_q;
    logic [LEN_SIZE-1:0]          len_raw;
    logic [LEN_SIZE-1:0]          len_eff;
    logic                         at_last;
    logic                         ready;
    logic                         load;
    logic                         advance;
    logic                         done;

    assign len_raw = name_len_in[ch*LEN_SIZE +: LEN_SIZE];
    assign len_eff = (len_raw > LEN_SIZE'(MAX_NAME_LENGTH)) ? LEN_SIZE'(MAX_NAME_LENGTH) : len_raw;
    assign idx_nxt = idx_q + 1'b1;
    assign at_last = (LEN_SIZE'(idx_q) + LEN_SIZE'(1)) == len_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Zero-length names are consumed through the ready handshake but never loaded.
    always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      load    = 1'b0;
      advance = 1'b0;
      done    = 1'b0;
      case (state_q)
        IDLE: begin
          ready = 1'b1;
          if (name_valid_in[ch] && (len_eff != '0)) begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (word_ready_in[ch]) begin
            if (at_last) begin
              done  = 1'b1;
              ready = 1'b1;
              if (name_valid_in[ch] && (len_eff != '0)) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              advance = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        name_q <= '0;
        len_q  <= '0;
        idx_q  <= '0;
        word_q <= '0;
      end else if (load) begin
        name_q <= name_in[ch*NAME_W +: NAME_W];
        len_q  <= len_eff;
        idx_q  <= '0;
        word_q <= name_in[ch*NAME_W +: WORD_SIZE];
      end else if (advance) begin
        idx_q  <= idx_nxt;
        word_q <= name_q[int'(idx_nxt)*WORD_SIZE +: WORD_SIZE];
      end else if (done) begin
        idx_q <= '0;
      end
    end

    assign issuing[ch]        = (state_q == ISSUE);
    assign name_ready_out[ch] = ready;
    assign word_valid_out[ch] = issuing[ch];
    assign word_first_out[ch] = issuing[ch] && (idx_q == '0);
    assign word_last_out[ch]  = issuing[ch] && at_last;
    assign word_out[ch*WORD_SIZE +: WORD_SIZE]                 = word_q;
    assign word_idx_out[ch*STRIDE_INDEX_SIZE +: STRIDE_INDEX_SIZE] = idx_q;

`ifdef NAME_ISSUE_STATS_EN
    logic [COUNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        cnt_q <= '0;
      end else if (done) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign names_issued_out[ch*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
`endif
  end

  assign busy_out = |issuing;

endmodule

// File: tb/tb_name_issue_unit.sv
// tb/tb_name_issue_unit.sv - self-checking bench for name_issue_unit
module tb_name_issue_unit;

  localparam int NC = 4;
  localparam int WS = 32;
  localparam int ML = 8;
  localparam int SI = 3;
  localparam int LS = 4;
  localparam int CW = 16;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in;
  logic [NC*WS*ML-1:0]   name_in;
  logic [NC*LS-1:0]      name_len_in;
  logic [NC-1:0]         name_valid_in;
  logic [NC-1:0]         name_ready_out;
  logic [NC*WS-1:0]      word_out;
  logic [NC*SI-1:0]      word_idx_out;
  logic [NC-1:0]         word_first_out;
  logic [NC-1:0]         word_last_out;
  logic [NC-1:0]         word_valid_out;
  logic [NC-1:0]         word_ready_in;
  logic                  busy_out;
`ifdef NAME_ISSUE_STATS_EN
  logic [NC*CW-1:0]      names_issued_out;
`endif

  name_issue_unit #(
    .NUM_CHANNELS(NC), .WORD_SIZE(WS), .MAX_NAME_LENGTH(ML),
    .STRIDE_INDEX_SIZE(SI), .LEN_SIZE(LS), .COUNT_WIDTH(CW)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .name_in(name_in), .name_len_in(name_len_in), .name_valid_in(name_valid_in),
    .name_ready_out(name_ready_out), .word_out(word_out), .word_idx_out(word_idx_out),
    .word_first_out(word_first_out), .word_last_out(word_last_out),
    .word_valid_out(word_valid_out), .word_ready_in(word_ready_in), .busy_out(busy_out)
`ifdef NAME_ISSUE_STATS_EN
    , .names_issued_out(names_issued_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int id, input int k);
    logic [31:0] i32, k32;
    i32 = id;
    k32 = k;
    return {i32[15:0], k32[15:0]};
  endfunction

  task automatic set_name(input int l, input int id, input int len, input bit v);
    logic [31:0] len32;
    len32 = len;
    for (int k = 0; k < ML; k++) name_in[(l*ML+k)*WS +: WS] = wd(id, k);
    name_len_in[l*LS +: LS] = len32[LS-1:0];
    name_valid_in[l] = v;
  endtask

  task automatic do_reset();
    rst_n_in      = 1'b0;
    name_valid_in = '0;
    word_ready_in = '1;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, word_valid_out, 0);
    chk({tag, "_ready"}, name_ready_out, {NC{1'b1}});
    chk({tag, "_word"},  word_out, 0);
    chk({tag, "_idx"},   word_idx_out, 0);
    chk({tag, "_first"}, word_first_out, 0);
    chk({tag, "_last"},  word_last_out, 0);
    chk({tag, "_busy"},  busy_out, 0);
`ifdef NAME_ISSUE_STATS_EN
    chk({tag, "_cnt"},   names_issued_out, 0);
`endif
  endtask

  typedef struct {
    bit v; int len; int id; bit rdy;
    bit ev; int eidx; bit ef; bit el; bit er; int eid;
  } vec_t;

  function automatic vec_t mk(bit v, int len, int id, bit rdy,
                              bit ev, int eidx, bit ef, bit el, bit er, int eid);
    vec_t r;
    r.v = v; r.len = len; r.id = id; r.rdy = rdy;
    r.ev = ev; r.eidx = eidx; r.ef = ef; r.el = el; r.er = er; r.eid = eid;
    return r;
  endfunction

  typedef struct {
    logic [31:0] w;
    int          idx;
    bit          f;
    bit          l;
  } ent_t;

  ent_t mq[NC][$];
  int   mcount[NC];

  vec_t tbl[$];

  initial begin
    name_in       = '0;
    name_len_in   = '0;
    name_valid_in = '0;
    word_ready_in = '1;
    rst_n_in      = 1'b0;
    #2 chk_reset_vals("reset");
    do_reset();

    // Lane 0 directed table: len 3, stall, len 0 cases, len 12 clamp, back-to-back.
    tbl.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0, 1, 1, 1));
    tbl.push_back(mk(1, 2, 2, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(1, 0, 9, 1, 1, 1, 0, 1, 1, 2));
    tbl.push_back(mk(1, 0, 9, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 12, 3, 1, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 7; k++) tbl.push_back(mk(0, 0, 0, 1, 1, k, k == 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 4, 1, 1, 7, 0, 1, 1, 3));
    tbl.push_back(mk(1, 2, 5, 1, 1, 0, 1, 1, 1, 4));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 1, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));

    foreach (tbl[i]) begin
      @(posedge clk_in); #1;
      set_name(0, tbl[i].id, tbl[i].len, tbl[i].v);
      word_ready_in[0] = tbl[i].rdy;
      @(negedge clk_in);
      chk($sformatf("tbl%0d_valid", i), word_valid_out[0], tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), name_ready_out[0], tbl[i].er);
      chk($sformatf("tbl%0d_busy", i),  busy_out, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_idx", i),   word_idx_out[SI-1:0], tbl[i].eidx);
        chk($sformatf("tbl%0d_first", i), word_first_out[0], tbl[i].ef);
        chk($sformatf("tbl%0d_last", i),  word_last_out[0], tbl[i].el);
        chk($sformatf("tbl%0d_word", i),  word_out[WS-1:0], wd(tbl[i].eid, tbl[i].eidx));
      end
    end
`ifdef NAME_ISSUE_STATS_EN
    chk("tbl_count", names_issued_out[CW-1:0], 5);
`endif

    // Back-to-back: two length-8 names with no gap.
    @(posedge clk_in); #1;
    set_name(0, 10, 8, 1);
    @(negedge clk_in);
    chk("b2b_accept_ready", name_ready_out[0], 1);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_in); #1;
      set_name(0, 11, 8, i < 15);
      @(negedge clk_in);
      chk($sformatf("b2b%0d_valid", i), word_valid_out[0], 1);
      chk($sformatf("b2b%0d_word", i),  word_out[WS-1:0], wd(i < 8 ? 10 : 11, i % 8));
      chk($sformatf("b2b%0d_ready", i), name_ready_out[0], (i % 8) == 7);
    end
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("b2b_idle", word_valid_out[0], 0);

    // Reset during word 4 of 8, then a fresh name.
    @(posedge clk_in); #1;
    set_name(0, 20, 8, 1);
    @(posedge clk_in); #1;
    name_valid_in[0] = 1'b0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_pre_idx", word_idx_out[SI-1:0], 4);
    #1 rst_n_in = 1'b0;
    #1 chk_reset_vals("midrst");
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    set_name(0, 21, 2, 1);
    @(posedge clk_in); #1;
    name_valid_in[0] = 1'b0;
    @(negedge clk_in);
    chk("postrst_idx0", word_idx_out[SI-1:0], 0);
    chk("postrst_word0", word_out[WS-1:0], wd(21, 0));
    @(negedge clk_in);
    chk("postrst_last", word_last_out[0], 1);
    @(negedge clk_in);
    chk("postrst_idle", word_valid_out[0], 0);
`ifdef NAME_ISSUE_STATS_EN
    chk("postrst_count", names_issued_out[CW-1:0], 1);
`endif

    // Randomized multi-lane run against a queue model; starts with lengths 1,2,5,8.
    do_reset();
    for (int l = 0; l < NC; l++) begin
      mq[l].delete();
      mcount[l] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_in); #1;
      for (int l = 0; l < NC; l++) begin
        for (int k = 0; k < ML; k++) name_in[(l*ML+k)*WS +: WS] = $urandom;
        word_ready_in[l] = ($urandom_range(0, 3) != 0);
        if (c == 0) begin
          name_len_in[l*LS +: LS] = (l == 0) ? 4'd1 : (l == 1) ? 4'd2 : (l == 2) ? 4'd5 : 4'd8;
          name_valid_in[l] = 1'b1;
        end else if (c < 25) begin
          name_valid_in[l] = 1'b0;
        end else begin
          name_len_in[l*LS +: LS] = 4'($urandom_range(0, 15));
          name_valid_in[l] = ($urandom_range(0, 2) != 0);
        end
      end
      @(negedge clk_in);
      begin
        bit any_busy;
        any_busy = 1'b0;
        for (int l = 0; l < NC; l++) begin
          bit ev, er;
          int eff, len;
          ev = (mq[l].size() != 0);
          er = (mq[l].size() == 0) || (mq[l].size() == 1 && word_ready_in[l]);
          any_busy |= ev;
          chk($sformatf("rnd%0d_l%0d_valid", c, l), word_valid_out[l], ev);
          chk($sformatf("rnd%0d_l%0d_ready", c, l), name_ready_out[l], er);
          if (ev) begin
            chk($sformatf("rnd%0d_l%0d_word", c, l),  word_out[l*WS +: WS], mq[l][0].w);
            chk($sformatf("rnd%0d_l%0d_idx", c, l),   word_idx_out[l*SI +: SI], mq[l][0].idx);
            chk($sformatf("rnd%0d_l%0d_first", c, l), word_first_out[l], mq[l][0].f);
            chk($sformatf("rnd%0d_l%0d_last", c, l),  word_last_out[l], mq[l][0].l);
          end
`ifdef NAME_ISSUE_STATS_EN
          chk($sformatf("rnd%0d_l%0d_cnt", c, l), names_issued_out[l*CW +: CW], mcount[l] % (1 << CW));
`endif
          if (ev && word_ready_in[l]) begin
            if (mq[l][0].l) mcount[l]++;
            void'(mq[l].pop_front());
          end
          len = int'(name_len_in[l*LS +: LS]);
          eff = (len > ML) ? ML : len;
          if (er && name_valid_in[l]) begin
            for (int k = 0; k < eff; k++) begin
              ent_t e;
              e.w = name_in[(l*ML+k)*WS +: WS];
              e.idx = k;
              e.f = (k == 0);
              e.l = (k == eff - 1);
              mq[l].push_back(e);
            end
          end
        end
        chk($sformatf("rnd%0d_busy", c), busy_out, any_busy);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
